// File: rtl/alu_wb_buffer.sv
// Write-back buffer between the ALU units and the register-file write port.
// Holds DEPTH results in order and serves operand-forwarding lookups from them.
module alu_wb_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_vld,
  output logic                  ex_rdy,
  input  logic [1:0]            ex_op_sel,
  input  logic [RD_WIDTH-1:0]   ex_rd_addr,
  input  logic                  ex_rd_wen,
  input  logic [DATA_WIDTH-1:0] adder_data_out,
  input  logic [DATA_WIDTH-1:0] logic_data_out,
  input  logic                  logic_out_vld,
  input  logic [DATA_WIDTH-1:0] comp_data_out,
  input  logic [DATA_WIDTH-1:0] shifter_data_out,
  input  logic                  shifter_out_vld,
  output logic                  wb_vld,
  input  logic                  wb_rdy,
  output logic [RD_WIDTH-1:0]   wb_rd_addr,
  output logic                  wb_wen,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_illegal,
  input  logic [RD_WIDTH-1:0]   fwd_rs1_addr,
  input  logic [RD_WIDTH-1:0]   fwd_rs2_addr,
  output logic                  fwd_rs1_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic                  fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] sel_result(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] add_r,
    input logic [DATA_WIDTH-1:0] log_r,
    input logic [DATA_WIDTH-1:0] cmp_r,
    input logic [DATA_WIDTH-1:0] shf_r
  );
    logic [DATA_WIDTH-1:0] res;
    case (sel)
      2'd0:    res = add_r;
      2'd1:    res = log_r;
      2'd2:    res = cmp_r;
      default: res = shf_r;
    endcase
    return res;
  endfunction

  function automatic logic op_illegal(
    input logic [1:0] sel,
    input logic       log_vld,
    input logic       shf_vld
  );
    return ((sel == 2'd1) && !log_vld) || ((sel == 2'd3) && !shf_vld);
  endfunction

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [DATA_WIDTH-1:0] r_data_p1 [DEPTH];
  logic [RD_WIDTH-1:0]   r_rd_p1   [DEPTH];
  logic                  r_wen_p1  [DEPTH];
  logic                  r_ill_p1  [DEPTH];

  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_illegal;
  logic                  w_push_wen;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_nonempty  = (r_count != '0);
  assign ex_rdy      = (r_count != CNT_FULL);
  assign w_push      = ex_vld && ex_rdy;
  assign w_pop       = w_nonempty && wb_rdy;

  // Illegal results are stored as zero and never write the register file.
  assign w_illegal   = op_illegal(ex_op_sel, logic_out_vld, shifter_out_vld);
  assign w_push_data = w_illegal ? '0 : sel_result(ex_op_sel, adder_data_out, logic_data_out,
                                                   comp_data_out, shifter_data_out);
  assign w_push_wen  = ex_rd_wen && !w_illegal && (ex_rd_addr != '0);

  // Stage p1: entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_data_p1[r_wr_ptr] <= w_push_data;
      r_rd_p1[r_wr_ptr]   <= ex_rd_addr;
      r_wen_p1[r_wr_ptr]  <= w_push_wen;
      r_ill_p1[r_wr_ptr]  <= w_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation; stale storage is masked while the buffer is empty.
  assign wb_vld     = w_nonempty;
  assign wb_rd_addr = w_nonempty ? r_rd_p1[r_rd_ptr]   : '0;
  assign wb_wen     = w_nonempty ? r_wen_p1[r_rd_ptr]  : 1'b0;
  assign wb_data    = w_nonempty ? r_data_p1[r_rd_ptr] : '0;
  assign wb_illegal = w_nonempty ? r_ill_p1[r_rd_ptr]  : 1'b0;

  // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
  always_comb begin : fwd_lookup
    logic [PTR_W-1:0] idx;
    idx          = r_rd_ptr;
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_wen_p1[idx]) begin
        if ((fwd_rs1_addr != '0) && (r_rd_p1[idx] == fwd_rs1_addr)) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = r_data_p1[idx];
        end
        if ((fwd_rs2_addr != '0) && (r_rd_p1[idx] == fwd_rs2_addr)) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = r_data_p1[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: a scoreboard queue of expected write-backs
// drained by a monitor, plus direct checks on flow control and forwarding.
module tb_alu_wb_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_vld;
  logic        ex_rdy;
  logic [1:0]  ex_op_sel;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic [31:0] adder_data_out;
  logic [31:0] logic_data_out;
  logic        logic_out_vld;
  logic [31:0] comp_data_out;
  logic [31:0] shifter_data_out;
  logic        shifter_out_vld;
  logic        wb_vld;
  logic        wb_rdy;
  logic [4:0]  wb_rd_addr;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic        wb_illegal;
  logic [4:0]  fwd_rs1_addr;
  logic [4:0]  fwd_rs2_addr;
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_data;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  alu_wb_buffer #(.DATA_WIDTH(32), .RD_WIDTH(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_op_sel(ex_op_sel),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .adder_data_out(adder_data_out), .logic_data_out(logic_data_out),
    .logic_out_vld(logic_out_vld), .comp_data_out(comp_data_out),
    .shifter_data_out(shifter_data_out), .shifter_out_vld(shifter_out_vld),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_rd_addr(wb_rd_addr),
    .wb_wen(wb_wen), .wb_data(wb_data), .wb_illegal(wb_illegal),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-selected buses carry distinctive junk so a wrong mux choice shows up.
  task automatic set_op(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                        input logic [31:0] d, input logic v, input logic ewen,
                        input logic [31:0] edata, input logic eill);
    exp_t e;
    ex_vld           = 1'b1;
    ex_op_sel        = sel;
    ex_rd_addr       = rd;
    ex_rd_wen        = wen;
    adder_data_out   = (sel == 2'd0) ? d : 32'hDEAD0000;
    logic_data_out   = (sel == 2'd1) ? d : 32'hBEEF0001;
    comp_data_out    = (sel == 2'd2) ? d : 32'h0000C0C0;
    shifter_data_out = (sel == 2'd3) ? d : 32'h5A5A5A5A;
    logic_out_vld    = v;
    shifter_out_vld  = v;
    if (ex_rdy && !flush && !rst) begin
      e.rd   = rd;
      e.wen  = ewen;
      e.data = edata;
      e.ill  = eill;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic wen,
                       input logic [31:0] d, input logic v, input logic ewen,
                       input logic [31:0] edata, input logic eill);
    set_op(sel, rd, wen, d, v, ewen, edata, eill);
    tick();
    ex_vld = 1'b0;
  endtask

  // Monitor: an entry is consumed at the next edge when vld&&rdy and no flush/reset.
  always @(negedge clk) begin
    if (!rst && !flush && wb_vld && wb_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", wb_data);
      end else begin
        exp_t e;
        exp_t got;
        e        = sb.pop_front();
        got.rd   = wb_rd_addr;
        got.wen  = wb_wen;
        got.data = wb_data;
        got.ill  = wb_illegal;
        if (got !== e) begin
          errors++;
          $display("FAIL sb_wb actual=rd%0d/wen%0b/%08h/ill%0b required=rd%0d/wen%0b/%08h/ill%0b",
                   got.rd, got.wen, got.data, got.ill, e.rd, e.wen, e.data, e.ill);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0; wb_rdy = 1'b0;
    ex_vld = 1'b1; ex_op_sel = 2'd0; ex_rd_addr = 5'd1; ex_rd_wen = 1'b1;
    adder_data_out = 32'h12345678; logic_data_out = 32'h0; logic_out_vld = 1'b1;
    comp_data_out = 32'h0; shifter_data_out = 32'h0; shifter_out_vld = 1'b1;
    fwd_rs1_addr = 5'd1; fwd_rs2_addr = 5'd1;

    // Reset held two cycles with ex_vld asserted
    tick(); tick();
    rst = 1'b0; ex_vld = 1'b0;
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_ex_rdy", ex_rdy, 1);
    chk("rst_wb_fields", {wb_rd_addr, wb_wen, wb_data, wb_illegal}, 0);
    chk("rst_fwd", {fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit}, 0);
    tick();
    chk("rst_stays_empty", wb_vld, 0);

    // Basic push with one-cycle latency
    wb_rdy = 1'b1;
    set_op(2'd0, 5'd5, 1'b1, 32'h0000000E, 1'b0, 1'b1, 32'h0000000E, 1'b0);
    chk("no_comb_path", wb_vld, 0);
    tick();
    ex_vld = 1'b0;
    chk("basic_vld", wb_vld, 1);
    chk("basic_head", {wb_rd_addr, wb_wen, wb_data}, {5'd5, 1'b1, 32'h0000000E});
    tick();
    chk("basic_drained", wb_vld, 0);

    // Fill under backpressure, refuse a third push, then drain in order
    wb_rdy = 1'b0;
    issue(2'd1, 5'd3, 1'b1, 32'hFF0F0FF0, 1'b1, 1'b1, 32'hFF0F0FF0, 1'b0);
    issue(2'd3, 5'd4, 1'b1, 32'h80000000, 1'b1, 1'b1, 32'h80000000, 1'b0);
    chk("full_ex_rdy", ex_rdy, 0);
    set_op(2'd0, 5'd6, 1'b1, 32'h00000066, 1'b1, 1'b1, 32'h00000066, 1'b0);
    tick();
    chk("full_hold_rdy", ex_rdy, 0);
    chk("full_head_stable", {wb_rd_addr, wb_data}, {5'd3, 32'hFF0F0FF0});
    wb_rdy = 1'b1;
    tick();
    ex_vld = 1'b0;
    chk("pop_no_push_rdy", ex_rdy, 1);
    chk("pop_second_head", wb_data, 32'h80000000);
    tick();
    chk("third_refused", wb_vld, 0);

    // Illegal results and x0 destinations
    issue(2'd3, 5'd7, 1'b1, 32'h00001234, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(2'd2, 5'd0, 1'b1, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b0);
    issue(2'd1, 5'd8, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(2'd0, 5'd2, 1'b0, 32'h00000042, 1'b0, 1'b0, 32'h00000042, 1'b0);
    tick(); tick();
    chk("illegal_drained", wb_vld, 0);

    // Forwarding: youngest match wins, x0 never hits
    wb_rdy = 1'b0;
    issue(2'd0, 5'd9, 1'b1, 32'h00000011, 1'b1, 1'b1, 32'h00000011, 1'b0);
    issue(2'd0, 5'd9, 1'b1, 32'h00000022, 1'b1, 1'b1, 32'h00000022, 1'b0);
    fwd_rs1_addr = 5'd9; fwd_rs2_addr = 5'd0;
    #1;
    chk("fwd_rs1_young", {fwd_rs1_hit, fwd_rs1_data}, {1'b1, 32'h00000022});
    chk("fwd_rs2_x0", {fwd_rs2_hit, fwd_rs2_data}, 0);
    fwd_rs2_addr = 5'd5;
    #1;
    chk("fwd_rs2_miss", {fwd_rs2_hit, fwd_rs2_data}, 0);

    // Flush with buffer full and ex_vld asserted
    flush = 1'b1;
    sb.delete();
    set_op(2'd0, 5'd10, 1'b1, 32'h00000033, 1'b1, 1'b1, 32'h00000033, 1'b0);
    #1;
    chk("fwd_during_flush", {fwd_rs1_hit, fwd_rs1_data}, {1'b1, 32'h00000022});
    tick();
    flush = 1'b0; ex_vld = 1'b0;
    chk("flush_empty", {wb_vld, ex_rdy}, 2'b01);
    chk("flush_fwd_clear", fwd_rs1_hit, 0);

    // Flush beats an accepted push on a partly filled buffer
    issue(2'd0, 5'd11, 1'b1, 32'h00000044, 1'b1, 1'b1, 32'h00000044, 1'b0);
    flush = 1'b1;
    sb.delete();
    set_op(2'd0, 5'd10, 1'b1, 32'h00000055, 1'b1, 1'b1, 32'h00000055, 1'b0);
    tick();
    flush = 1'b0; ex_vld = 1'b0;
    fwd_rs1_addr = 5'd10;
    #1;
    chk("flush_drops_push", {wb_vld, fwd_rs1_hit}, 0);
    tick();
    chk("flush_no_reappear", wb_vld, 0);

    // Streaming push+pop every cycle wraps the pointers
    wb_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(2'd0, 5'(i + 1), 1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
      tick();
    end
    ex_vld = 1'b0;
    tick();
    chk("stream_drained", wb_vld, 0);

    // Youngest-wins with wrapped pointers
    wb_rdy = 1'b0;
    issue(2'd2, 5'd12, 1'b1, 32'h0000000A, 1'b1, 1'b1, 32'h0000000A, 1'b0);
    issue(2'd0, 5'd12, 1'b1, 32'h0000000B, 1'b1, 1'b1, 32'h0000000B, 1'b0);
    fwd_rs1_addr = 5'd12; fwd_rs2_addr = 5'd12;
    #1;
    chk("fwd_wrap_young", {fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data},
        {1'b1, 32'h0000000B, 1'b1, 32'h0000000B});
    wb_rdy = 1'b1;
    tick(); tick(); tick();
    chk("final_empty", {wb_vld, fwd_rs1_hit}, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
